spi_regbank: RTL and testbench

Parametrised SPI mode-0 register bank: the next generation of the single-write SPI peripheral that holds the output-enable, PWM-enable and duty-cycle registers. It adds a configurable register count and width, burst writes with address auto-increment, register read-back on CIPO, and framing-error reporting. It sits between the chip pads (sclk/ncs/copi/cipo) and the PWM/output logic, running entirely in the system clock domain.

---
 rtl/spi_regbank.sv | 204 ++++++++++++++++++++
 tb/tb_spi_regbank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 register bank with burst write, read-back
// and framing-error reporting, all in the clk domain.
module spi_regbank #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int CW = 6;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDATA
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sq, ncs_sq, copi_sq;
  logic [SYNC_STAGES-1:0] flush_q;
  logic sclk_h_q, ncs_h_q, armed_q, armed_d;
  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  state_t state_q, state_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, so_q, so_d, rd_word;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic rw_q, rw_d, commit;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0] stb_q, stb_d;
  logic err_q, err_d, oe_q, oe_d;

  assign sclk_s = sclk_sq[SYNC_STAGES-1];
  assign ncs_s  = ncs_sq[SYNC_STAGES-1];
  assign copi_s = copi_sq[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_h_q;
  assign sclk_fall = ~sclk_s & sclk_h_q;
  assign ncs_rise  = ncs_s & ~ncs_h_q;
  // A frame may only start once ncs was seen high after reset.
  assign ncs_fall  = ~ncs_s & ncs_h_q & armed_q;
  assign armed_d   = armed_q | (flush_q[SYNC_STAGES-1] & ncs_s);

  // Pin synchronisers, edge history and post-reset arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sq  <= '0;
      ncs_sq   <= '1;
      copi_sq  <= '0;
      sclk_h_q <= 1'b0;
      ncs_h_q  <= 1'b1;
      flush_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      sclk_sq  <= (sclk_sq << 1) | SYNC_STAGES'(sclk);
      ncs_sq   <= (ncs_sq << 1) | SYNC_STAGES'(ncs);
      copi_sq  <= (copi_sq << 1) | SYNC_STAGES'(copi);
      sclk_h_q <= sclk_s;
      ncs_h_q  <= ncs_s;
      flush_q  <= (flush_q << 1) | SYNC_STAGES'(1);
      armed_q  <= armed_d;
    end
  end

  // Register selected by the pointer; zero when out of range.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr_q == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
    end
  end

  assign ptr_inc = (&ptr_q) ? ptr_q : ptr_q + ADDR_W'(1);

  // Frame FSM, shifters, pointer and register-file next state.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    so_d    = so_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    if (ncs_rise) begin
      err_d   = (state_q == ADDR) ||
                (((state_q == WDATA) || (state_q == RDATA)) &&
                 (bcnt_q != '0));
      state_d = IDLE;
      bcnt_d  = '0;
      so_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_d = CMD;
            bcnt_d  = '0;
            sh_d    = '0;
            so_d    = '0;
            ptr_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rw_d    = copi_s;
            state_d = ADDR;
            bcnt_d  = '0;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            ptr_d = (ptr_q << 1) | ADDR_W'(copi_s);
            if (bcnt_q == CW'(ADDR_W - 1)) begin
              bcnt_d  = '0;
              state_d = rw_q ? WDATA : RDATA;
            end else begin
              bcnt_d = bcnt_q + CW'(1);
            end
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            sh_d = (sh_q << 1) | DATA_W'(copi_s);
            if (bcnt_q == CW'(DATA_W - 1)) begin
              bcnt_d = '0;
              commit = 1'b1;
              ptr_d  = ptr_inc;
            end else begin
              bcnt_d = bcnt_q + CW'(1);
            end
          end
        end
        RDATA: begin
          if (sclk_rise) begin
            bcnt_d = (bcnt_q == CW'(DATA_W - 1)) ? '0 : bcnt_q + CW'(1);
          end
          if (sclk_fall) begin
            if (bcnt_q == '0) begin
              so_d  = rd_word;
              ptr_d = ptr_inc;
            end else begin
              so_d = so_q << 1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    oe_d = (state_d == RDATA);
  end

  // Commit a completed write word to the addressed register.
  always_comb begin
    regs_d = regs_q;
    stb_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      stb_d[i] = commit && (ptr_q == ADDR_W'(i));
      if (stb_d[i]) regs_d[i*DATA_W +: DATA_W] = sh_d;
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      so_q    <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      regs_q  <= '0;
      stb_q   <= '0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      regs_q  <= regs_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
    end
  end

  assign cipo      = so_q[DATA_W-1];
  assign cipo_oe   = oe_q;
  assign reg_q     = regs_q;
  assign wr_strobe = stb_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: directed SPI frames against a default instance and a
// wide-data instance, with a write/read scoreboard.
module tb_spi_regbank;

  localparam int H  = 4;
  localparam int H2 = 5;

  logic clk = 1'b0;
  logic rst, sclk, ncs, ncs2, copi;
  logic cipo, cipo_oe, frame_err;
  logic [39:0] reg_q;
  logic [4:0] wr_strobe;
  logic cipo2, cipo_oe2, frame_err2;
  logic [47:0] reg_q2;
  logic [2:0] wr_strobe2;

  always #5 clk = ~clk;

  spi_regbank dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .reg_q(reg_q),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  spi_regbank #(
    .NUM_REGS(3), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(3)
  ) dut2 (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs2), .copi(copi),
    .cipo(cipo2), .cipo_oe(cipo_oe2), .reg_q(reg_q2),
    .wr_strobe(wr_strobe2), .frame_err(frame_err2)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wexp_t;

  wexp_t wq[$];
  logic [7:0] rq[$];
  logic [39:0] exp_regs;
  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int err2_cnt = 0;
  int stb2_cnt = 0;
  logic [2:0] stb2_bits = '0;
  logic oe_any, oe_all;

  task automatic chk(string tag, logic [47:0] obs, logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe pops one expected write.
  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (frame_err2) err2_cnt++;
    if (wr_strobe2 != '0) begin
      stb2_cnt++;
      stb2_bits = stb2_bits | wr_strobe2;
    end
    if (wr_strobe != '0) begin
      chk("wr_expected", 48'(wq.size() > 0), 48'd1);
      if (wq.size() > 0) begin
        wexp_t e;
        e = wq.pop_front();
        chk("wr_strobe", 48'(wr_strobe), 48'(5'b1 << e.idx));
        chk("wr_data", 48'(reg_q[e.idx*8 +: 8]), 48'(e.data));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, input int h,
                         output logic o, output logic oe);
    copi = b;
    tick(h);
    o  = cipo;
    oe = cipo_oe;
    sclk = 1'b1;
    tick(h);
    sclk = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n, input int h);
    logic o, oe;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], h, o, oe);
      oe_any = oe_any | oe;
    end
  endtask

  task automatic recv(input string tag);
    logic o, oe;
    logic [7:0] w;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, H, o, oe);
      w[i] = o;
      oe_all = oe_all & oe;
    end
    chk({tag, "_pending"}, 48'(rq.size() > 0), 48'd1);
    if (rq.size() > 0) chk(tag, 48'(w), 48'(rq.pop_front()));
  endtask

  task automatic exp_wr(input int idx, input logic [7:0] d);
    wexp_t e;
    e.idx = idx;
    e.data = d;
    wq.push_back(e);
    exp_regs[idx*8 +: 8] = d;
  endtask

  task automatic fbeg(input bit two, input int h);
    if (two) ncs2 = 1'b0;
    else ncs = 1'b0;
    oe_any = 1'b0;
    oe_all = 1'b1;
    tick(h);
  endtask

  task automatic fend(input bit two, input int h);
    tick(h);
    if (two) ncs2 = 1'b1;
    else ncs = 1'b1;
    tick(3 * h);
  endtask

  initial begin
    int e0;
    rst = 1'b1; sclk = 1'b0; ncs = 1'b1; ncs2 = 1'b1; copi = 1'b0;
    exp_regs = '0;
    tick(3);
    chk("rst_reg_q", 48'(reg_q), 48'd0);
    chk("rst_outs", 48'({cipo, cipo_oe, frame_err, wr_strobe}), 48'd0);
    rst = 1'b0;
    tick(6);

    // single write
    exp_wr(2, 8'hA5);
    fbeg(0, H); send(1, 1, H); send(7'h02, 7, H); send(8'hA5, 8, H);
    fend(0, H);
    chk("wr_single", 48'(reg_q), 48'(exp_regs));
    chk("wr_single_err", 48'(err_cnt), 48'd0);

    // burst with out-of-range third word
    exp_wr(3, 8'h11); exp_wr(4, 8'h22);
    fbeg(0, H); send(1, 1, H); send(7'h03, 7, H);
    send(24'h112233, 24, H); fend(0, H);
    chk("wr_burst", 48'(reg_q), 48'(exp_regs));
    chk("wr_burst_err", 48'(err_cnt), 48'd0);
    chk("wr_burst_q", 48'(wq.size()), 48'd0);

    // read-back
    exp_wr(0, 8'h5A); exp_wr(1, 8'hC3);
    fbeg(0, H); send(1, 1, H); send(7'h00, 7, H);
    send(16'h5AC3, 16, H); fend(0, H);
    rq.push_back(8'h5A); rq.push_back(8'hC3);
    chk("rd_oe_idle", 48'(cipo_oe), 48'd0);
    fbeg(0, H); send(0, 1, H); send(7'h00, 7, H);
    chk("rd_oe_hdr", 48'(oe_any), 48'd0);
    recv("rd_w0"); recv("rd_w1");
    chk("rd_oe_data", 48'(oe_all), 48'd1);
    fend(0, H);
    chk("rd_oe_end", 48'(cipo_oe), 48'd0);

    // out-of-range read
    rq.push_back(8'h00);
    fbeg(0, H); send(0, 1, H); send(7'h10, 7, H);
    recv("rd_oor"); fend(0, H);
    chk("rd_err", 48'(err_cnt), 48'd0);

    // abort after 12 bits of a write
    e0 = err_cnt;
    fbeg(0, H); send(1, 1, H); send(7'h01, 7, H); send(4'hF, 4, H);
    fend(0, H);
    chk("abort12_err", 48'(err_cnt - e0), 48'd1);
    chk("abort12_regs", 48'(reg_q), 48'(exp_regs));

    // abort after 4 address bits
    e0 = err_cnt;
    fbeg(0, H); send(1, 1, H); send(4'h0, 4, H); fend(0, H);
    chk("abort_addr_err", 48'(err_cnt - e0), 48'd1);
    chk("abort_addr_regs", 48'(reg_q), 48'(exp_regs));

    // reset mid-frame, trailing edges ignored
    e0 = err_cnt;
    fbeg(0, H); send(1, 1, H); send(7'h00, 7, H); send(2'b11, 2, H);
    rst = 1'b1;
    #1;
    exp_regs = '0;
    chk("midrst_reg_q", 48'(reg_q), 48'd0);
    chk("midrst_outs",
        48'({cipo, cipo_oe, frame_err, wr_strobe}), 48'd0);
    tick(2);
    rst = 1'b0;
    send(6'h3F, 6, H);
    fend(0, H);
    chk("midrst_trail", 48'(reg_q), 48'd0);
    exp_wr(0, 8'hFF);
    fbeg(0, H); send(1, 1, H); send(7'h00, 7, H); send(8'hFF, 8, H);
    fend(0, H);
    chk("midrst_wr", 48'(reg_q), 48'(exp_regs));
    chk("midrst_err", 48'(err_cnt - e0), 48'd0);

    // wide instance at minimum sclk period
    fbeg(1, H2); send(1, 1, H2); send(4'h2, 4, H2);
    send(16'hBEEF, 16, H2); fend(1, H2);
    chk("p2_reg_q", reg_q2, {16'hBEEF, 32'h0});
    chk("p2_stb", 48'({stb2_bits, 8'(stb2_cnt)}), 48'({3'b100, 8'd1}));
    chk("p2_err", 48'(err2_cnt), 48'd0);
    chk("dut1_quiet", 48'(reg_q), 48'(exp_regs));
    chk("wq_empty", 48'(wq.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
